// File: rtl/program_sequencer_if.sv
// Program-load and issue bus between the sequencer and its host/core array.
// The master side loads RAM and starts/stops runs; the slave side is the sequencer.
interface program_sequencer_if #(
  parameter int ADDR_W = 5
) ();
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic              start;
  logic              stop;
  logic [15:0]       opcode;
  logic              execute;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] pc;

  modport master (
    output prog_we, prog_addr, prog_data, start, stop,
    input  opcode, execute, busy, done, pc
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, stop,
    output opcode, execute, busy, done, pc
  );
endinterface

// File: rtl/program_sequencer.sv
// Instruction fetch/issue stage: steps through a small program RAM and drives the
// shared opcode/execute bus, resolving LDC/DJNZ/HALT locally.
//
// state | meaning
// IDLE  | waiting for start; RAM writable; execute low
// RUN   | one fetch per cycle; busy high
module program_sequencer #(
  parameter int DEPTH  = 32,
  parameter int LOOP_W = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic                clk,
  input logic                rst_n,
  program_sequencer_if.slave bus
);
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [15:0]       mem [DEPTH];
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [LOOP_W-1:0] loop_q, loop_d;
  logic [15:0]       opcode_q, opcode_d;
  logic              exec_q, exec_d;
  logic              done_q, done_d;
  logic [15:0]       word;
  logic              is_halt, is_ldc, is_djnz, taken, at_end, finish;

  assign word    = mem[pc_q];
  assign is_halt = (word[15:12] == 4'b1001);
  assign is_ldc  = (word[15:12] == 4'b1010);
  assign is_djnz = (word[15:12] == 4'b1011);
  assign taken   = is_djnz && (loop_q > LOOP_W'(1));
  assign at_end  = (pc_q == ADDR_W'(DEPTH - 1));
  // A taken branch from the last word is still honoured; anything else there ends the run.
  assign finish  = is_halt || (at_end && !taken);

  always_ff @(posedge clk) begin
    if (bus.prog_we && state_q == S_IDLE) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      loop_q   <= '0;
      opcode_q <= 16'h0000;
      exec_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      loop_q   <= loop_d;
      opcode_q <= opcode_d;
      exec_q   <= exec_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (bus.stop || finish) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    loop_d   = loop_q;
    opcode_d = opcode_q;
    exec_d   = 1'b0;
    done_d   = 1'b0;
    if (state_q == S_IDLE) begin
      if (bus.start) pc_d = '0;
    end else if (bus.stop) begin
      pc_d = '0;
    end else begin
      opcode_d = word;
      exec_d   = !(is_halt || is_ldc || is_djnz);
      if (is_ldc)  loop_d = word[LOOP_W-1:0];
      if (is_djnz) loop_d = taken ? loop_q - LOOP_W'(1) : '0;
      pc_d = taken ? word[ADDR_W-1:0] : pc_q + ADDR_W'(1);
      if (finish) begin
        pc_d   = '0;
        done_d = 1'b1;
      end
    end
  end

  assign bus.opcode  = opcode_q;
  assign bus.execute = exec_q;
  assign bus.busy    = (state_q == S_RUN);
  assign bus.done    = done_q;
  assign bus.pc      = pc_q;
endmodule

// File: tb/tb_program_sequencer.sv
// Directed and randomized checks of program_sequencer against an instruction-level
// interpreter of the program RAM.
module tb_program_sequencer;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  program_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  program_sequencer #(.DEPTH(DEPTH), .LOOP_W(8), .ADDR_W(ADDR_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [15:0]       m_mem [DEPTH];
  int unsigned       m_cnt;
  logic [15:0]       e_op [$];
  logic              e_ex [$];
  logic [ADDR_W-1:0] e_pc [$];
  bit                e_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Interpret the program one fetch per step; each step is one issue slot.
  task automatic model_run(input int max_steps);
    int          p;
    int          s;
    logic [15:0] w;
    p = 0;
    s = 0;
    e_op.delete(); e_ex.delete(); e_pc.delete();
    e_halt = 0;
    while (!e_halt && s < max_steps) begin
      w = m_mem[p];
      e_op.push_back(w);
      case (w[15:12])
        4'h9: begin e_ex.push_back(1'b0); e_halt = 1; end
        4'hA: begin e_ex.push_back(1'b0); m_cnt = w[7:0]; p++; end
        4'hB: begin
          e_ex.push_back(1'b0);
          if (m_cnt > 1) begin m_cnt--; p = w[4:0]; end
          else begin m_cnt = 0; p++; end
        end
        default: begin e_ex.push_back(1'b1); p++; end
      endcase
      if (p >= DEPTH) e_halt = 1;
      if (e_halt) p = 0;
      e_pc.push_back(ADDR_W'(p));
      s++;
    end
  endtask

  task automatic write_word(input int a, input logic [15:0] d);
    @(negedge clk);
    bus.prog_we = 1'b1; bus.prog_addr = ADDR_W'(a); bus.prog_data = d;
    m_mem[a] = d;
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  // Runs the program; stops it after max_steps if it has not halted by then.
  // Optionally writes word 0 in the start cycle and tries a write at run_wr_a mid-run.
  task automatic run_prog(input int max_steps, input bit sw, input logic [15:0] sw_d,
                          input bit run_wr, input int run_wr_a);
    int  n;
    bit  last;
    @(negedge clk);
    if (sw) begin
      bus.prog_we = 1'b1; bus.prog_addr = '0; bus.prog_data = sw_d;
      m_mem[0] = sw_d;
    end
    model_run(max_steps);
    n = e_op.size();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.prog_we = 1'b0;
    check("busy_after_start", bus.busy, 1);
    check("exec_after_start", bus.execute, 0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      last = e_halt && (i == n - 1);
      check("execute", bus.execute, e_ex[i]);
      check("opcode", bus.opcode, e_op[i]);
      check("pc", bus.pc, e_pc[i]);
      check("done", bus.done, last);
      check("busy", bus.busy, !last);
      bus.start   = (i == 0 && n > 1);
      bus.prog_we = run_wr && (i == 0);
      bus.prog_addr = ADDR_W'(run_wr_a);
      bus.prog_data = 16'h5555;
    end
    if (!e_halt) bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0; bus.start = 1'b0; bus.prog_we = 1'b0;
    check("end_execute", bus.execute, 0);
    check("end_done", bus.done, 0);
    check("end_busy", bus.busy, 0);
    check("end_pc", bus.pc, 0);
  endtask

  initial begin
    int r;
    logic [15:0] w;
    bus.prog_we = 0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.start = 0; bus.stop = 0;
    m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h9000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle with stop asserted: nothing moves.
    bus.stop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_execute", bus.execute, 0);
      check("idle_opcode", bus.opcode, 0);
      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);
    end
    bus.stop = 1'b0;

    // Zero loop count: DJNZ falls through.
    write_word(0, 16'hB005); write_word(1, 16'h0777); write_word(2, 16'h9000);
    run_prog(100, 0, 16'h0, 0, 0);

    write_word(0, 16'h0105); write_word(1, 16'h4A04); write_word(2, 16'h9000);
    run_prog(100, 0, 16'h0, 0, 0);

    write_word(0, 16'hA003); write_word(1, 16'h4A04);
    write_word(2, 16'hB001); write_word(3, 16'h9000);
    run_prog(100, 0, 16'h0, 0, 0);

    for (int i = 0; i < DEPTH; i++) write_word(i, 16'h0100);
    run_prog(100, 0, 16'h0, 0, 0);

    // Long loop stopped early; the mid-run write must be dropped.
    write_word(0, 16'hA0C8); write_word(1, 16'h1234);
    write_word(2, 16'hB001); write_word(3, 16'h9000);
    run_prog(3, 0, 16'h0, 1, 1);
    run_prog(12, 0, 16'h0, 0, 0);

    // Asynchronous reset mid-run.
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_execute", bus.execute, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_opcode", bus.opcode, 0);
    check("rst_pc", bus.pc, 0);
    m_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
    run_prog(9, 0, 16'h0, 0, 0);

    // Random programs; every other run writes word 0 in the start cycle.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < DEPTH; i++) begin
        r = $urandom_range(0, 99);
        if (r < 60)      w = {4'($urandom_range(0, 8)), 12'($urandom)};
        else if (r < 75) w = {8'hA0, 8'($urandom_range(0, 4))};
        else if (r < 92) w = {11'b10110000000, 5'($urandom_range(0, DEPTH - 1))};
        else             w = {4'h9, 12'($urandom)};
        write_word(i, w);
      end
      run_prog(150, t[0], {4'h0, 12'($urandom)}, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
